// File: rtl/rs232_pkg.sv
// Shared constants and FSM encoding for the RS-232 command parser.
// ASCII codes for line endings and command letters, plus letter classifiers.
package rs232_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_R_LC = 8'h72;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_EOL   = 3'd3,
        S_ISSUE = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    function automatic logic is_write_char(input logic [7:0] c);
        return (c == ASCII_W) || (c == ASCII_W_LC);
    endfunction

    function automatic logic is_read_char(input logic [7:0] c);
        return (c == ASCII_R) || (c == ASCII_R_LC);
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one ASCII byte.
// Flags hex digits (either case) and line endings, and produces the nibble value.
module ascii_hex_decode
    import rs232_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_hex,
    output logic       is_eol,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        is_eol = (data == ASCII_CR) || (data == ASCII_LF);
        if (data >= 8'h30 && data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data[3:0];
        end else if ((data >= 8'h41 && data <= 8'h46) ||
                     (data >= 8'h61 && data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 gives 10..15.
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/rs232_cmd_parser.sv
// Parses "W<addr><data><EOL>" / "R<addr><EOL>" lines popped from the RS-232 RX FIFO
// and offers each decoded command on a valid/ready interface; bad lines are flushed.
module rs232_cmd_parser
    import rs232_pkg::*;
#(
    parameter int P_ADDR_NIBBLES = 4,
    parameter int P_DATA_NIBBLES = 4
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_fifo_data,
    input  logic                        rx_fifo_empty,
    output logic                        rx_fifo_rd_en,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic                        cmd_we,
    output logic [4*P_ADDR_NIBBLES-1:0] cmd_addr,
    output logic [4*P_DATA_NIBBLES-1:0] cmd_wdata,
    output logic                        err,
    output logic [7:0]                  err_cnt
);

    localparam int AW    = 4 * P_ADDR_NIBBLES;
    localparam int DW    = 4 * P_DATA_NIBBLES;
    localparam int MAX_N = (P_ADDR_NIBBLES > P_DATA_NIBBLES) ? P_ADDR_NIBBLES : P_DATA_NIBBLES;
    localparam int CW    = $clog2(MAX_N + 1);

    state_t          state;
    logic            byte_vld;
    logic [CW-1:0]   nib_cnt;
    logic            is_hex;
    logic            is_eol;
    logic [3:0]      nibble;
    logic            is_cmd;
    logic            bad_byte;

    ascii_hex_decode u_decode (
        .data   (rx_fifo_data),
        .is_hex (is_hex),
        .is_eol (is_eol),
        .nibble (nibble)
    );

    // byte_vld doubles as the read-in-flight flag, limiting us to one pop per two clocks.
    assign rx_fifo_rd_en = !rst && !rx_fifo_empty && !byte_vld && (state != S_ISSUE);
    assign is_cmd        = is_write_char(rx_fifo_data) || is_read_char(rx_fifo_data);

    always_comb begin
        bad_byte = 1'b0;
        if (byte_vld) begin
            case (state)
                S_IDLE:         bad_byte = !is_cmd && !is_eol;
                S_ADDR, S_DATA: bad_byte = !is_hex;
                S_EOL:          bad_byte = !is_eol;
                default:        bad_byte = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_vld  <= 1'b0;
            nib_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            err      <= 1'b0;
            byte_vld <= rx_fifo_rd_en;
            case (state)
                S_IDLE: begin
                    cmd_addr  <= '0;
                    cmd_wdata <= '0;
                    nib_cnt   <= '0;
                    if (byte_vld && is_cmd) begin
                        cmd_we <= is_write_char(rx_fifo_data);
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (byte_vld && is_hex) begin
                        cmd_addr <= (cmd_addr << 4) | AW'(nibble);
                        if (nib_cnt == CW'(P_ADDR_NIBBLES - 1)) begin
                            nib_cnt <= '0;
                            state   <= cmd_we ? S_DATA : S_EOL;
                        end else begin
                            nib_cnt <= nib_cnt + CW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (byte_vld && is_hex) begin
                        cmd_wdata <= (cmd_wdata << 4) | DW'(nibble);
                        if (nib_cnt == CW'(P_DATA_NIBBLES - 1)) begin
                            nib_cnt <= '0;
                            state   <= S_EOL;
                        end else begin
                            nib_cnt <= nib_cnt + CW'(1);
                        end
                    end
                end
                S_EOL: begin
                    if (byte_vld && is_eol) begin
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (byte_vld && is_eol) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A bad EOL already ends the line, so only other bytes need a flush.
            if (bad_byte) begin
                err   <= 1'b1;
                state <= is_eol ? S_IDLE : S_FLUSH;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
